// File: rtl/ws2811_frame_ctrl.sv
// ws2811_frame_ctrl: walks the pixel RAM once per START and serialises each
// 24-bit {G,R,B} word MSB-first as WS2811 pulse-width bits, then holds the
// line low for the latch gap and pulses DONE.
module ws2811_frame_ctrl #(
  parameter int unsigned NUM_LEDS = 64,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned T_BIT    = 30,
  parameter int unsigned T0H      = 6,
  parameter int unsigned T1H      = 14,
  parameter int unsigned T_LATCH  = 600
) (
  input  logic              i_clkin,
  input  logic              i_reset,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_re,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [23:0]       i_rdata,
  output logic              o_dout
);

  localparam int unsigned CNT_W = $clog2(T_BIT);
  localparam int unsigned LAT_W = $clog2(T_LATCH + 1);
  localparam int unsigned BIT_W = 5;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0]  HI_ZERO  = CNT_W'(T0H);
  localparam logic [CNT_W-1:0]  HI_ONE   = CNT_W'(T1H);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(T_LATCH - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NUM_LEDS - 1);
  localparam logic [BIT_W-1:0]  BIT_MSB  = BIT_W'(23);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SEND  = 3'd3,
    S_LATCH = 3'd4
  } state_t;

  state_t             r_state, w_state_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic [LAT_W-1:0]   r_lcnt, w_lcnt_n;
  logic [ADDR_W-1:0]  r_pix, w_pix_n;
  logic [BIT_W-1:0]   r_bit, w_bit_n;
  logic [23:0]        r_shreg, w_shreg_n;
  logic [23:0]        r_buf, w_buf_n;
  logic               r_pend, w_pend_n;
  logic               r_busy, w_busy_n;
  logic               r_done, w_done_n;
  logic               r_dout, w_dout_n;
  logic               w_prefetch;

  // Next pixel is requested at the very start of the current pixel's first bit
  assign w_prefetch = (r_state == S_SEND) && (r_bit == BIT_MSB) &&
                      (r_cnt == '0) && (r_pix != PIX_LAST);

  // RAM port decoded from registered state only
  assign o_re    = (r_state == S_FETCH) || w_prefetch;
  assign o_raddr = w_prefetch ? (r_pix + ADDR_W'(1)) : '0;

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_dout = r_dout;

  // State register
  always_ff @(posedge i_clkin or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_n;
  end

  // Next-state and next-value decode; DOUT is computed one cycle ahead so the
  // registered pin lines up with the period counter
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_lcnt_n  = r_lcnt;
    w_pix_n   = r_pix;
    w_bit_n   = r_bit;
    w_shreg_n = r_shreg;
    w_buf_n   = r_pend ? i_rdata : r_buf;
    w_pend_n  = w_prefetch;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    w_dout_n  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_n = S_FETCH;
          w_busy_n  = 1'b1;
          w_pix_n   = '0;
        end
      end
      S_FETCH: begin
        w_state_n = S_LOAD;
      end
      S_LOAD: begin
        w_shreg_n = i_rdata;
        w_bit_n   = BIT_MSB;
        w_cnt_n   = '0;
        w_state_n = S_SEND;
      end
      S_SEND: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_n = '0;
          if (r_bit == '0) begin
            if (r_pix == PIX_LAST) begin
              w_state_n = S_LATCH;
              w_lcnt_n  = '0;
            end else begin
              w_shreg_n = r_buf;
              w_pix_n   = r_pix + ADDR_W'(1);
              w_bit_n   = BIT_MSB;
            end
          end else begin
            w_shreg_n = {r_shreg[22:0], 1'b0};
            w_bit_n   = r_bit - BIT_W'(1);
          end
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      S_LATCH: begin
        if (r_lcnt == LAT_LAST) begin
          w_state_n = S_IDLE;
          w_done_n  = 1'b1;
          w_busy_n  = 1'b0;
        end else begin
          w_lcnt_n = r_lcnt + LAT_W'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_busy_n  = 1'b0;
      end
    endcase

    if (w_state_n == S_SEND)
      w_dout_n = (w_cnt_n < (w_shreg_n[23] ? HI_ONE : HI_ZERO));
  end

  // Datapath and output registers
  always_ff @(posedge i_clkin or posedge i_reset) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_lcnt  <= '0;
      r_pix   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_buf   <= '0;
      r_pend  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dout  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_n;
      r_lcnt  <= w_lcnt_n;
      r_pix   <= w_pix_n;
      r_bit   <= w_bit_n;
      r_shreg <= w_shreg_n;
      r_buf   <= w_buf_n;
      r_pend  <= w_pend_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_dout  <= w_dout_n;
    end
  end

endmodule
